// File: rtl/pkg_6801.sv
// Shared 6801 core types: sequencer control selects, interrupt source codes and vector offsets.
package pkg_6801;

  typedef enum logic [1:0] {
    LEFT_ACCA,
    LEFT_ACCB,
    LEFT_IX,
    LEFT_MD
  } left_ctrl_type;

  typedef enum logic [1:0] {
    RIGHT_MD,
    RIGHT_ZERO,
    RIGHT_ONE,
    RIGHT_ACCB
  } right_ctrl_type;

  typedef enum logic [1:0] {
    NMI_NOP,
    NMI_SET,
    NMI_CLR
  } nmi_ctrl_type;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_NMI,
    SRC_IRQ1,
    SRC_ICF,
    SRC_OCF,
    SRC_TOF,
    SRC_SCI
  } int_src_type;

  typedef enum logic {
    ST_IDLE,
    ST_SERVICE
  } int_state_type;

  // Vector offsets above VEC_BASE; SCI sits at the base itself.
  localparam logic [15:0] VEC_OFS_NMI  = 16'h000C;
  localparam logic [15:0] VEC_OFS_IRQ1 = 16'h0008;
  localparam logic [15:0] VEC_OFS_ICF  = 16'h0006;
  localparam logic [15:0] VEC_OFS_OCF  = 16'h0004;
  localparam logic [15:0] VEC_OFS_TOF  = 16'h0002;
  localparam logic [15:0] VEC_OFS_SCI  = 16'h0000;

endpackage

// File: rtl/int_prio_enc_6801.sv
// Fixed-priority interrupt encoder: masked requests in, winning source and vector out.
module int_prio_enc_6801
  import pkg_6801::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFE,
  parameter logic [15:0] VEC_BASE  = 16'hFFF0
) (
  input  logic        nmi,
  input  logic        irq1,
  input  logic        icf,
  input  logic        ocf,
  input  logic        tof,
  input  logic        sci,
  output int_src_type src,
  output logic [15:0] vec
);

  always_comb begin
    src = SRC_NONE;
    vec = RESET_VEC;
    if (nmi) begin
      src = SRC_NMI;
      vec = VEC_BASE + VEC_OFS_NMI;
    end else if (irq1) begin
      src = SRC_IRQ1;
      vec = VEC_BASE + VEC_OFS_IRQ1;
    end else if (icf) begin
      src = SRC_ICF;
      vec = VEC_BASE + VEC_OFS_ICF;
    end else if (ocf) begin
      src = SRC_OCF;
      vec = VEC_BASE + VEC_OFS_OCF;
    end else if (tof) begin
      src = SRC_TOF;
      vec = VEC_BASE + VEC_OFS_TOF;
    end else if (sci) begin
      src = SRC_SCI;
      vec = VEC_BASE + VEC_OFS_SCI;
    end
  end

endmodule

// File: rtl/int_ctrl_6801.sv
// 6801 interrupt controller: pin sync, NMI edge latch, I-mask, priority and service handshake.
// Build option INT_SYNC_EN selects a two-flop pin synchronizer instead of a single input register.
module int_ctrl_6801
  import pkg_6801::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFE,
  parameter logic [15:0] VEC_BASE  = 16'hFFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        nmi_n,
  input  logic        irq1_n,
  input  logic        icf_irq,
  input  logic        ocf_irq,
  input  logic        tof_irq,
  input  logic        sci_irq,
  input  logic        i_mask,
  input  logic        take_int,
  input  logic        svc_done,
  output logic        int_req,
  output logic        wai_wake,
  output int_src_type int_src,
  output logic [15:0] vector,
  output logic        nmi_ack
);

  logic          nmi_sync;
  logic          irq1_sync;
  logic          nmi_hist;
  logic          nmi_edge;
  logic          nmi_latch;
  logic          latch_nx;
  logic          ack_nx;
  logic          pending;
  int_state_type state;
  int_state_type state_nx;
  int_src_type   src_q;
  int_src_type   src_nx;
  int_src_type   win_src;
  logic [15:0]   vec_q;
  logic [15:0]   vec_nx;
  logic [15:0]   win_vec;

`ifdef INT_SYNC_EN
  logic nmi_p0, nmi_p1, irq1_p0, irq1_p1;

  // Pin synchronizer stages p0 -> p1; frozen with the rest of the block on hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_p0  <= 1'b1;
      nmi_p1  <= 1'b1;
      irq1_p0 <= 1'b1;
      irq1_p1 <= 1'b1;
    end else if (!hold) begin
      nmi_p0  <= nmi_n;
      nmi_p1  <= nmi_p0;
      irq1_p0 <= irq1_n;
      irq1_p1 <= irq1_p0;
    end
  end

  assign nmi_sync  = nmi_p1;
  assign irq1_sync = irq1_p1;
`else
  logic nmi_p0, irq1_p0;

  // Single input register stage p0 for pins already synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_p0  <= 1'b1;
      irq1_p0 <= 1'b1;
    end else if (!hold) begin
      nmi_p0  <= nmi_n;
      irq1_p0 <= irq1_n;
    end
  end

  assign nmi_sync  = nmi_p0;
  assign irq1_sync = irq1_p0;
`endif

  // Edge history stage; a 1 -> 0 step on the synchronized pin is an NMI edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_hist <= 1'b1;
    end else if (!hold) begin
      nmi_hist <= nmi_sync;
    end
  end

  assign nmi_edge = nmi_hist & ~nmi_sync;

  int_prio_enc_6801 #(
    .RESET_VEC (RESET_VEC),
    .VEC_BASE  (VEC_BASE)
  ) u_prio (
    .nmi  (nmi_latch),
    .irq1 (~i_mask & ~irq1_sync),
    .icf  (~i_mask & icf_irq),
    .ocf  (~i_mask & ocf_irq),
    .tof  (~i_mask & tof_irq),
    .sci  (~i_mask & sci_irq),
    .src  (win_src),
    .vec  (win_vec)
  );

  assign pending  = nmi_latch |
                    (~i_mask & (~irq1_sync | icf_irq | ocf_irq | tof_irq | sci_irq));
  assign int_req  = pending & (state == ST_IDLE);
  assign wai_wake = pending;
  assign vector   = (state == ST_IDLE) ? win_vec : vec_q;
  assign int_src  = src_q;

  always_comb begin
    state_nx = state;
    latch_nx = nmi_latch;
    ack_nx   = nmi_ack;
    src_nx   = src_q;
    vec_nx   = vec_q;
    case (state)
      ST_IDLE: begin
        if (take_int && pending) begin
          state_nx = ST_SERVICE;
          src_nx   = win_src;
          vec_nx   = win_vec;
          if (win_src == SRC_NMI) begin
            latch_nx = 1'b0;
            ack_nx   = 1'b1;
          end
        end
      end
      ST_SERVICE: begin
        if (svc_done) begin
          state_nx = ST_IDLE;
          ack_nx   = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // A fresh edge overrides a same-cycle clear so no NMI is dropped.
    if (nmi_edge) latch_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      nmi_latch <= 1'b0;
      nmi_ack   <= 1'b0;
      src_q     <= SRC_NONE;
      vec_q     <= RESET_VEC;
    end else if (!hold) begin
      state     <= state_nx;
      nmi_latch <= latch_nx;
      nmi_ack   <= ack_nx;
      src_q     <= src_nx;
      vec_q     <= vec_nx;
    end
  end

endmodule

// File: tb/tb_int_ctrl_6801.sv
// Bench for int_ctrl_6801: directed scenarios plus randomized traffic against a queue-based model.
module tb_int_ctrl_6801;
  import pkg_6801::*;

`ifdef INT_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, hold, nmi_n, irq1_n, icf_irq, ocf_irq, tof_irq, sci_irq;
  logic        i_mask, take_int, svc_done;
  logic        int_req, wai_wake, nmi_ack;
  int_src_type int_src;
  logic [15:0] vector;

  int checks = 0;
  int failures = 0;

  int_ctrl_6801 dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .nmi_n    (nmi_n),
    .irq1_n   (irq1_n),
    .icf_irq  (icf_irq),
    .ocf_irq  (ocf_irq),
    .tof_irq  (tof_irq),
    .sci_irq  (sci_irq),
    .i_mask   (i_mask),
    .take_int (take_int),
    .svc_done (svc_done),
    .int_req  (int_req),
    .wai_wake (wai_wake),
    .int_src  (int_src),
    .vector   (vector),
    .nmi_ack  (nmi_ack)
  );

  always #5 clk = ~clk;

  // Reference model: pin sample history (index 0 newest) and service bookkeeping.
  bit          nq[$];
  bit          iq[$];
  bit          m_nmi, m_busy, m_ack;
  int_src_type m_src;
  logic [15:0] m_vec;

  localparam logic [15:0] VT [6] = '{16'hFFFC, 16'hFFF8, 16'hFFF6, 16'hFFF4, 16'hFFF2, 16'hFFF0};
  localparam int_src_type ST [6] = '{SRC_NMI, SRC_IRQ1, SRC_ICF, SRC_OCF, SRC_TOF, SRC_SCI};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_winner();
    if (m_nmi) return 0;
    if (i_mask) return -1;
    if (!iq[D-1]) return 1;
    if (icf_irq) return 2;
    if (ocf_irq) return 3;
    if (tof_irq) return 4;
    if (sci_irq) return 5;
    return -1;
  endfunction

  task automatic m_reset();
    nq.delete();
    iq.delete();
    for (int k = 0; k <= D; k++) begin
      nq.push_back(1'b1);
      iq.push_back(1'b1);
    end
    m_nmi  = 1'b0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_src  = SRC_NONE;
    m_vec  = 16'hFFFE;
  endtask

  task automatic cmp_all();
    int w;
    w = m_winner();
    #1;
    chk("int_req", int_req, (w >= 0) && !m_busy);
    chk("wai_wake", wai_wake, w >= 0);
    chk("vector", vector, m_busy ? m_vec : ((w >= 0) ? VT[w] : 16'hFFFE));
    chk("nmi_ack", nmi_ack, m_ack);
    chk("int_src", int_src, m_src);
  endtask

  // Advance one clock: update the model with the inputs held across this edge.
  task automatic tick();
    int  w;
    bit  edge_seen;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (!hold) begin
      w = m_winner();
      edge_seen = nq[D] && !nq[D-1];
      if (!m_busy && take_int && w >= 0) begin
        m_busy = 1'b1;
        m_src  = ST[w];
        m_vec  = VT[w];
        if (w == 0) begin
          m_nmi = 1'b0;
          m_ack = 1'b1;
        end
      end else if (m_busy && svc_done) begin
        m_busy = 1'b0;
        m_ack  = 1'b0;
      end
      if (edge_seen) m_nmi = 1'b1;
      nq.push_front(nmi_n);
      void'(nq.pop_back());
      iq.push_front(irq1_n);
      void'(iq.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic step();
    cmp_all();
    tick();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; nmi_n = 1'b1; irq1_n = 1'b1;
    icf_irq = 1'b0; ocf_irq = 1'b0; tof_irq = 1'b0; sci_irq = 1'b0;
    i_mask = 1'b1; take_int = 1'b0; svc_done = 1'b0;
    m_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;
    step();

    // Reset/idle values
    chk("rst_int_req", int_req, 1'b0);
    chk("rst_vector", vector, 16'hFFFE);
    chk("rst_int_src", int_src, SRC_NONE);
    chk("rst_nmi_ack", nmi_ack, 1'b0);

    // OCF beats TOF; request withdrawn during service, back after svc_done
    i_mask = 1'b0; ocf_irq = 1'b1; tof_irq = 1'b1;
    #1;
    chk("ocf_req", int_req, 1'b1);
    chk("ocf_vec", vector, 16'hFFF4);
    take_int = 1'b1; step(); take_int = 1'b0;
    step();
    chk("ocf_src", int_src, SRC_OCF);
    chk("ocf_busy_req", int_req, 1'b0);
    svc_done = 1'b1; step(); svc_done = 1'b0;
    #1;
    chk("ocf_again", int_req, 1'b1);
    ocf_irq = 1'b0; tof_irq = 1'b0;
    take_int = 1'b1; step(); take_int = 1'b0;
    svc_done = 1'b1; step(); svc_done = 1'b0;

    // NMI latency with IRQ1 masked
    i_mask = 1'b1; irq1_n = 1'b0;
    step(); step();
    nmi_n = 1'b0;
    for (int k = 0; k <= D; k++) begin
      #1;
      chk("nmi_lat_low", int_req, 1'b0);
      step();
    end
    #1;
    chk("nmi_lat_req", int_req, 1'b1);
    chk("nmi_lat_vec", vector, 16'hFFFC);
    take_int = 1'b1; step(); take_int = 1'b0;
    #1;
    chk("nmi_ack_set", nmi_ack, 1'b1);
    chk("nmi_src", int_src, SRC_NMI);

    // Second NMI edge while in service
    nmi_n = 1'b1;
    for (int k = 0; k <= D; k++) step();
    nmi_n = 1'b0;
    for (int k = 0; k <= D; k++) step();
    #1;
    chk("svc_wake", wai_wake, 1'b1);
    chk("svc_no_req", int_req, 1'b0);
    svc_done = 1'b1; step(); svc_done = 1'b0;
    #1;
    chk("nmi2_req", int_req, 1'b1);
    chk("nmi2_vec", vector, 16'hFFFC);
    chk("nmi2_ack_clr", nmi_ack, 1'b0);

    // New edge lands on the take_int cycle: NMI stays pending
    nmi_n = 1'b1;
    for (int k = 0; k <= D; k++) step();
    nmi_n = 1'b0;
    for (int k = 0; k < D; k++) step();
    take_int = 1'b1; step(); take_int = 1'b0;
    #1;
    chk("coll_ack", nmi_ack, 1'b1);
    chk("coll_pend", wai_wake, 1'b1);
    svc_done = 1'b1; step(); svc_done = 1'b0;
    #1;
    chk("coll_req", int_req, 1'b1);

    // take_int under hold is ignored, then accepted after hold drops
    hold = 1'b1; take_int = 1'b1; step();
    #1;
    chk("hold_ack", nmi_ack, 1'b0);
    chk("hold_req", int_req, 1'b1);
    hold = 1'b0; step(); take_int = 1'b0;
    #1;
    chk("hold_take", nmi_ack, 1'b1);

    // Reset while in service with an NMI latched
    nmi_n = 1'b1;
    for (int k = 0; k <= D; k++) step();
    nmi_n = 1'b0;
    for (int k = 0; k <= D; k++) step();
    #1;
    chk("pre_rst_pend", wai_wake, 1'b1);
    rst = 1'b1; step(); rst = 1'b0; nmi_n = 1'b1;
    #1;
    chk("post_rst_req", int_req, 1'b0);
    chk("post_rst_vec", vector, 16'hFFFE);
    chk("post_rst_ack", nmi_ack, 1'b0);
    chk("post_rst_wake", wai_wake, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      hold     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
      irq1_n   = ($urandom_range(0, 3) != 0);
      icf_irq  = ($urandom_range(0, 5) == 0);
      ocf_irq  = ($urandom_range(0, 5) == 0);
      tof_irq  = ($urandom_range(0, 5) == 0);
      sci_irq  = ($urandom_range(0, 5) == 0);
      i_mask   = ($urandom_range(0, 2) == 0);
      take_int = ($urandom_range(0, 3) == 0);
      svc_done = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
